// File: rtl/custom_axi_regbank.sv
// ============================================================================
// custom_axi_regbank
//   Register bank with a small reduction engine (SUM/XOR/MAX/CLEAR) that
//   folds the operand registers into the top (result) register.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module custom_axi_regbank #(
   parameter int NUM_REGS = 4,
   parameter int DW       = 32
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [NUM_REGS-1:0]    reg_wr_de_i,
   input  logic [NUM_REGS*DW-1:0] reg_wr_q_i,
   output logic [NUM_REGS*DW-1:0] reg_rd_d_o,
   output logic [NUM_REGS-1:0]    reg_rd_de_o,
   input  logic                   cmd_start_i,
   input  logic [1:0]             cmd_op_i,
   input  logic                   done_clr_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   irq_o,
   output logic                   wr_drop_o
);

   localparam int IW = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REGS - 2);

   localparam logic [1:0] OP_SUM   = 2'b00;
   localparam logic [1:0] OP_XOR   = 2'b01;
   localparam logic [1:0] OP_MAX   = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_FINISH = 2'd2
   } state_e;

   typedef logic [NUM_REGS-1:0][DW-1:0] bank_t;

   state_e                state_q, state_d;
   bank_t                 regs_q, regs_d;
   bank_t                 wr_data;
   logic [DW-1:0]         acc_q, acc_d;
   logic [DW-1:0]         operand;
   logic [IW-1:0]         idx_q, idx_d;
   logic [1:0]            op_q, op_d;
   logic                  done_q, done_d;
   logic                  irq_q, irq_d;
   logic                  wr_drop_q, wr_drop_d;
   logic [NUM_REGS-1:0]   rd_de_q, rd_de_d;

   assign wr_data     = reg_wr_q_i;
   assign reg_rd_d_o  = regs_q;
   assign reg_rd_de_o = rd_de_q;
   assign busy_o      = (state_q != S_IDLE);
   assign done_o      = done_q;
   assign irq_o       = irq_q;
   assign wr_drop_o   = wr_drop_q;
   assign operand     = regs_q[idx_q];

   always_comb begin
      state_d   = state_q;
      regs_d    = regs_q;
      acc_d     = acc_q;
      idx_d     = idx_q;
      op_d      = op_q;
      done_d    = done_q;
      irq_d     = 1'b0;
      wr_drop_d = 1'b0;
      rd_de_d   = '0;

      if (done_clr_i) begin
         done_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            // Bus writes land on the same edge a start is accepted, so the
            // engine's first operand read already sees the new value.
            for (int i = 0; i < NUM_REGS; i++) begin
               if (reg_wr_de_i[i]) begin
                  regs_d[i] = wr_data[i];
               end
            end
            rd_de_d = reg_wr_de_i;
            if (cmd_start_i) begin
               op_d    = cmd_op_i;
               done_d  = 1'b0;
               idx_d   = '0;
               acc_d   = '0;
               state_d = (cmd_op_i == OP_CLEAR) ? S_FINISH : S_RUN;
            end
         end

         S_RUN: begin
            wr_drop_d = |reg_wr_de_i;
            case (op_q)
               OP_SUM:  acc_d = acc_q + operand;
               OP_XOR:  acc_d = acc_q ^ operand;
               OP_MAX:  acc_d = (operand > acc_q) ? operand : acc_q;
               default: acc_d = acc_q;
            endcase
            if (idx_q == LAST_IDX) begin
               state_d = S_FINISH;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end

         S_FINISH: begin
            wr_drop_d = |reg_wr_de_i;
            if (op_q == OP_CLEAR) begin
               regs_d  = '0;
               rd_de_d = '1;
            end else begin
               regs_d[NUM_REGS-1]  = acc_q;
               rd_de_d[NUM_REGS-1] = 1'b1;
            end
            // Completion wins over a coincident done_clr_i.
            done_d  = 1'b1;
            irq_d   = 1'b1;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= S_IDLE;
         regs_q    <= '0;
         acc_q     <= '0;
         idx_q     <= '0;
         op_q      <= OP_SUM;
         done_q    <= 1'b0;
         irq_q     <= 1'b0;
         wr_drop_q <= 1'b0;
         rd_de_q   <= '0;
      end else begin
         state_q   <= state_d;
         regs_q    <= regs_d;
         acc_q     <= acc_d;
         idx_q     <= idx_d;
         op_q      <= op_d;
         done_q    <= done_d;
         irq_q     <= irq_d;
         wr_drop_q <= wr_drop_d;
         rd_de_q   <= rd_de_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_custom_axi_regbank.sv
// ============================================================================
// tb_custom_axi_regbank
//   Directed-vector bench with queued expectations checked by a monitor.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_custom_axi_regbank;

   localparam int NR = 4;
   localparam int DW = 32;

   logic                 clk_i = 1'b0;
   logic                 rst_ni = 1'b0;
   logic [NR-1:0]        reg_wr_de_i = '0;
   logic [NR*DW-1:0]     reg_wr_q_i = '0;
   logic [NR*DW-1:0]     reg_rd_d_o;
   logic [NR-1:0]        reg_rd_de_o;
   logic                 cmd_start_i = 1'b0;
   logic [1:0]           cmd_op_i = 2'b00;
   logic                 done_clr_i = 1'b0;
   logic                 busy_o, done_o, irq_o, wr_drop_o;

   int n_vec  = 0;
   int n_miss = 0;

   logic [NR*DW-1:0] q_irq[$];
   logic [NR-1:0]    q_rdde[$];
   logic [DW-1:0]    q_drop[$];

   logic [NR*DW-1:0] e_irq;
   logic [NR-1:0]    e_rdde;
   logic [DW-1:0]    e_drop;

   custom_axi_regbank #(.NUM_REGS(NR), .DW(DW)) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .reg_wr_de_i (reg_wr_de_i),
      .reg_wr_q_i  (reg_wr_q_i),
      .reg_rd_d_o  (reg_rd_d_o),
      .reg_rd_de_o (reg_rd_de_o),
      .cmd_start_i (cmd_start_i),
      .cmd_op_i    (cmd_op_i),
      .done_clr_i  (done_clr_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .irq_o       (irq_o),
      .wr_drop_o   (wr_drop_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic unexpected(input string nm);
      n_vec++;
      n_miss++;
      $display("FAIL %s: unexpected event, got 1 expected 0", nm);
   endtask

   function automatic logic [NR*DW-1:0] pk(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [DW-1:0] c, input logic [DW-1:0] d);
      return {d, c, b, a};
   endfunction

   // Monitor: pops expectations whenever the DUT raises an event output.
   always @(negedge clk_i) begin
      if (rst_ni) begin
         if (irq_o) begin
            if (q_irq.size() == 0) begin
               unexpected("irq");
            end else begin
               e_irq = q_irq.pop_front();
               for (int k = 0; k < NR; k++) begin
                  chk($sformatf("irq_r%0d", k), reg_rd_d_o[k*DW +: DW], e_irq[k*DW +: DW]);
               end
               chk("irq_done", DW'(done_o), DW'(1));
            end
         end
         if (reg_rd_de_o != '0) begin
            if (q_rdde.size() == 0) begin
               unexpected("rd_de");
            end else begin
               e_rdde = q_rdde.pop_front();
               chk("rd_de_mask", DW'(reg_rd_de_o), DW'(e_rdde));
            end
         end
         if (wr_drop_o) begin
            if (q_drop.size() == 0) begin
               unexpected("wr_drop");
            end else begin
               e_drop = q_drop.pop_front();
               chk("drop_r1_kept", reg_rd_d_o[DW +: DW], e_drop);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic bus_wr(input logic [NR-1:0] m, input logic [NR*DW-1:0] d);
      reg_wr_de_i = m;
      reg_wr_q_i  = d;
      q_rdde.push_back(m);
      tick();
      reg_wr_de_i = '0;
   endtask

   task automatic start(input logic [1:0] op);
      cmd_start_i = 1'b1;
      cmd_op_i    = op;
      tick();
      cmd_start_i = 1'b0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy_o && n < 50) begin
         n++;
         tick();
      end
      if (n >= 50) chk("busy_timeout", DW'(busy_o), DW'(0));
   endtask

   int n;

   initial begin
      #2;
      chk("rst_busy",  DW'(busy_o), DW'(0));
      chk("rst_done",  DW'(done_o), DW'(0));
      chk("rst_irq",   DW'(irq_o), DW'(0));
      chk("rst_rd_de", DW'(reg_rd_de_o), DW'(0));
      chk("rst_r3",    reg_rd_d_o[3*DW +: DW], 32'h0);
      #10;
      rst_ni = 1'b1;
      tick();

      // SUM with wraparound: 5 + 7 + 0xFFFFFFFF
      bus_wr(4'b0111, pk(32'd5, 32'd7, 32'hFFFF_FFFF, 32'h0));
      q_irq.push_back(pk(32'd5, 32'd7, 32'hFFFF_FFFF, 32'h0000_000B));
      q_rdde.push_back(4'b1000);
      start(2'b00);
      wait_idle(n);
      chk("sum_busy_cycles", DW'(n), DW'(4));

      // XOR then MAX on the same operands
      bus_wr(4'b0111, pk(32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0000_00FF, 32'h0));
      q_irq.push_back(pk(32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0000_00FF, 32'hFFFF_FF00));
      q_rdde.push_back(4'b1000);
      start(2'b01);
      chk("done_cleared_by_start", DW'(done_o), DW'(0));
      wait_idle(n);
      chk("xor_busy_cycles", DW'(n), DW'(4));
      q_irq.push_back(pk(32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0000_00FF, 32'hF0F0_F0F0));
      q_rdde.push_back(4'b1000);
      start(2'b10);
      wait_idle(n);

      // Write and second start mid-RUN are dropped
      q_irq.push_back(pk(32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0000_00FF, 32'h0000_00FE));
      q_rdde.push_back(4'b1000);
      q_drop.push_back(32'h0F0F_0F0F);
      start(2'b00);
      reg_wr_de_i = 4'b0010;
      reg_wr_q_i  = pk(32'h0, 32'h0000_1234, 32'h0, 32'h0);
      cmd_start_i = 1'b1;
      cmd_op_i    = 2'b11;
      tick();
      reg_wr_de_i = '0;
      cmd_start_i = 1'b0;
      wait_idle(n);
      chk("drop_busy_remaining", DW'(n), DW'(3));
      chk("drop_r1_after", reg_rd_d_o[DW +: DW], 32'h0F0F_0F0F);

      // done_clr_i clears sticky done
      done_clr_i = 1'b1;
      tick();
      done_clr_i = 1'b0;
      chk("done_clr", DW'(done_o), DW'(0));

      // Write + start in one cycle; done_clr_i held across completion
      reg_wr_de_i = 4'b0111;
      reg_wr_q_i  = pk(32'd9, 32'd0, 32'd0, 32'd0);
      cmd_start_i = 1'b1;
      cmd_op_i    = 2'b00;
      done_clr_i  = 1'b1;
      q_rdde.push_back(4'b0111);
      q_rdde.push_back(4'b1000);
      q_irq.push_back(pk(32'd9, 32'd0, 32'd0, 32'd9));
      tick();
      reg_wr_de_i = '0;
      cmd_start_i = 1'b0;
      wait_idle(n);
      done_clr_i = 1'b0;
      chk("same_cycle_busy", DW'(n), DW'(4));
      tick();
      chk("done_sticky", DW'(done_o), DW'(1));

      // CLEAR with all registers nonzero
      bus_wr(4'b1111, pk(32'd1, 32'd2, 32'd3, 32'd4));
      q_rdde.push_back(4'b1111);
      q_irq.push_back(pk(32'd0, 32'd0, 32'd0, 32'd0));
      start(2'b11);
      wait_idle(n);
      chk("clear_busy_cycles", DW'(n), DW'(1));

      // Reset during RUN cycle 2
      bus_wr(4'b0111, pk(32'd1, 32'd2, 32'd3, 32'd0));
      start(2'b00);
      tick();
      #2;
      rst_ni = 1'b0;
      #1;
      chk("arst_busy",    DW'(busy_o), DW'(0));
      chk("arst_done",    DW'(done_o), DW'(0));
      chk("arst_irq",     DW'(irq_o), DW'(0));
      chk("arst_wr_drop", DW'(wr_drop_o), DW'(0));
      chk("arst_rd_de",   DW'(reg_rd_de_o), DW'(0));
      chk("arst_r0",      reg_rd_d_o[0 +: DW], 32'h0);
      tick();
      tick();
      rst_ni = 1'b1;
      repeat (6) tick();
      chk("arst_r3_after", reg_rd_d_o[3*DW +: DW], 32'h0);
      chk("arst_busy_after", DW'(busy_o), DW'(0));
      done_clr_i = 1'b1;
      tick();
      done_clr_i = 1'b0;
      chk("arst_done_after_clr", DW'(done_o), DW'(0));

      // First start after reset release is accepted
      bus_wr(4'b0011, pk(32'd3, 32'd4, 32'd0, 32'd0));
      q_rdde.push_back(4'b1000);
      q_irq.push_back(pk(32'd3, 32'd4, 32'd0, 32'd4));
      start(2'b10);
      wait_idle(n);
      chk("max_busy_cycles", DW'(n), DW'(4));

      repeat (3) tick();
      chk("irq_queue_drained",   DW'(q_irq.size()), DW'(0));
      chk("rd_de_queue_drained", DW'(q_rdde.size()), DW'(0));
      chk("drop_queue_drained",  DW'(q_drop.size()), DW'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire

// File: doc/custom_axi_regbank.md
CUSTOM_AXI_REGBANK -- requirements
Module: custom_axi_regbank

Interface
REQ-001 SHALL have parameter NUM_REGS, default 4, number of DW-bit registers (legal 2..16); register NUM_REGS-1 is the result register.
REQ-002 SHALL have parameter DW, default 32, register data width (legal 8..64).
REQ-003 SHALL have port clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-005 SHALL have port reg_wr_de_i  input  NUM_REGS  per-register write enable from the bus-side register interface.
REQ-006 SHALL have port reg_wr_q_i  input  NUM_REGS*DW  write data; slice i belongs to register i.
REQ-007 SHALL have port reg_rd_d_o  output  NUM_REGS*DW  current register contents, driven directly from register flops.
REQ-008 SHALL have port reg_rd_de_o  output  NUM_REGS  per-register update strobe toward bus-side shadow.
REQ-009 SHALL have port cmd_start_i  input  1  single-cycle start request.
REQ-010 SHALL have port cmd_op_i  input  2  operation: 00 SUM, 01 XOR, 10 MAX (unsigned), 11 CLEAR.
REQ-011 SHALL have port done_clr_i  input  1  clears sticky done flag.
REQ-012 SHALL have ports busy_o, done_o, irq_o, wr_drop_o  output  1 each  status: engine busy, sticky completion, completion pulse, dropped-write pulse.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, FINISH.
REQ-014 IDLE with cmd_start_i=1 and op in {SUM,XOR,MAX} SHALL latch op, set idx=0, load accumulator with identity (0 for all three), go to RUN.
REQ-015 IDLE with cmd_start_i=1 and op=CLEAR SHALL go directly to FINISH with latched op CLEAR.
REQ-016 RUN SHALL combine register[idx] into accumulator once per cycle for idx = 0..NUM_REGS-2, then go to FINISH; RUN lasts exactly NUM_REGS-1 cycles.
REQ-017 SUM SHALL wrap modulo 2^DW; XOR bitwise; MAX unsigned compare, ties keep accumulator.
REQ-018 FINISH (one cycle) SHALL write accumulator to register NUM_REGS-1 (or zero all registers for CLEAR), set done_o, pulse irq_o, return to IDLE.
REQ-019 busy_o SHALL be 1 in RUN and FINISH, 0 in IDLE.
REQ-020 irq_o SHALL be high exactly for the cycle after FINISH (registered); done_o SHALL rise in that same cycle and stay high until done_clr_i or next accepted start.
REQ-021 cmd_start_i while busy_o=1 SHALL be ignored with no side effect.
REQ-022 Bus write to register i while busy_o=0 SHALL update register i on that edge; reg_wr_de_i bits while busy_o=1 SHALL be dropped and wr_drop_o pulsed the next cycle.
REQ-023 Write and cmd_start_i in same IDLE cycle: write SHALL take effect and the operation SHALL use the newly written value.
REQ-024 done_clr_i coincident with completion SHALL lose; done_o SHALL be set.
REQ-025 reg_rd_de_o[i] SHALL pulse for one cycle in the cycle after register i is written by bus or FSM, independent of whether the value changed.
REQ-026 Operand registers 0..NUM_REGS-2 SHALL NOT be modified by SUM/XOR/MAX.

Reset
REQ-027 Asynchronous assertion of rst_ni SHALL immediately zero all registers, accumulator and idx, force IDLE, and drive busy_o, done_o, irq_o, wr_drop_o, reg_rd_de_o to 0.
REQ-028 Reset mid-RUN SHALL abort with no result write and no irq_o after deassertion.
REQ-029 After deassertion the first accepted start SHALL be the first rising edge with cmd_start_i=1.

Verification (NUM_REGS=4, DW=32)
REQ-030 Write r0=5, r1=7, r2=0xFFFFFFFF; start SUM -> busy_o 4 cycles, r3=0x0000000B, irq_o one pulse, done_o=1, reg_rd_de_o[3] pulse.
REQ-031 r0=0xF0F0F0F0, r1=0x0F0F0F0F, r2=0x000000FF; XOR -> r3=0xFFFFFF00; MAX on same -> r3=0xF0F0F0F0.
REQ-032 Write r1=0x1234 and start in mid-RUN -> wr_drop_o pulse, r1 unchanged, second start ignored, single irq_o.
REQ-033 Write r0=9 and start SUM in same cycle with r1=r2=0 -> r3=9.
REQ-034 CLEAR with all registers nonzero -> all four zero after 2 cycles, reg_rd_de_o=4'b1111 pulse, irq_o pulse.
REQ-035 Assert rst_ni=0 during RUN cycle 2 -> all outputs 0, r3 stays 0, no irq_o after release; done_clr_i then clears nothing.
